irq_arbiter: RTL and testbench
==============================

IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of interrupt sources (legal range 2..31).
REQ-002 SHALL have parameter PRIO_W, default 3, width of each source priority field.
REQ-003 SHALL have parameter EDGE_RST, default all-zero (NUM_SRC bits), reset value of the edge-mode mask.
REQ-004 SHALL derive ID_W = clog2(NUM_SRC+1); id 0 = none, id i+1 = source i.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 src_irq  in  NUM_SRC  raw source lines (e.g. DMA, WDT), asynchronous to clk.
REQ-008 cfg_we  in  1  config write strobe.
REQ-009 cfg_addr  in  8  byte address of the config register.
REQ-010 cfg_wdata  in  32  config write data.
REQ-011 cfg_rdata  out  32  combinational read of the register at cfg_addr; 0 for unmapped addresses.
REQ-012 stall  in  1  pipeline stall (IM or DM); claim and complete are ignored while high.
REQ-013 claim  in  1  one-cycle pulse: trap entry taken for irq_id.
REQ-014 complete  in  1  one-cycle pulse: ISR return (mret) for complete_id.
REQ-015 complete_id  in  ID_W  id being completed.
REQ-016 irq_req  out  1  registered interrupt request to the CSR block.
REQ-017 irq_id  out  ID_W  registered winning id; 0 whenever irq_req=0.

Function
REQ-018 Register map: 0x00 enable mask; 0x04 edge mask (1=edge, 0=level); 0x08 pending (read; write-1-to-clear, edge sources only); 0x0C threshold (PRIO_W bits); 0x10+4*i priority of source i.
REQ-019 Each src_irq bit SHALL pass a 2-flop synchronizer; edge detection is on synchronizer output vs. its previous value.
REQ-020 Per source, a 3-state FSM: IDLE, PEND, ACTIVE.
REQ-021 IDLE->PEND: edge mode on a synchronized rising edge; level mode while synchronized line is high.
REQ-022 Level mode PEND->IDLE when the synchronized line drops before claim.
REQ-023 PEND->ACTIVE on accepted claim with irq_id = that source; ACTIVE->IDLE on accepted complete with matching id.
REQ-024 Edge arriving while ACTIVE SHALL set a one-deep pend_next flag; on complete the source goes to PEND instead of IDLE. Further edges while PEND or pend_next set are merged.
REQ-025 Candidate = PEND & enabled & priority != 0 & priority > max(threshold, highest priority among ACTIVE sources).
REQ-026 Winner = highest priority candidate; ties go to the lowest index.
REQ-027 irq_req/irq_id SHALL register the winner every cycle; latency src_irq high -> irq_req high is exactly 4 clk edges.
REQ-028 Claim accepted only when stall=0 and irq_req=1; otherwise ignored. After accepted claim, irq_req deasserts (or shows the next winner) on the following edge.
REQ-029 Complete accepted only when stall=0 and complete_id names an ACTIVE source; otherwise ignored.
REQ-030 Claim and complete in the same cycle SHALL both apply.
REQ-031 W1C on pending in the same cycle as a new edge: set wins. W1C on an ACTIVE source's pend_next clears it.
REQ-032 Disabling a source retains its PEND state; it is merely excluded from arbitration.
REQ-033 Pending readback bit i = (state==PEND) | pend_next.

Reset
REQ-034 On rst low, asynchronously: all FSMs IDLE, pend_next 0, synchronizers 0, enable 0, edge mask EDGE_RST, threshold 0, all priorities 0, irq_req 0, irq_id 0.
REQ-035 Reset mid-ISR SHALL drop ACTIVE state; no pending survives reset.

Verification
REQ-036 src0 level, enable=1, prio0=2, raise src_irq[0] -> irq_req=1, irq_id=1 exactly 4 edges later.
REQ-037 src1 prio 3, src2 prio 3, both pending -> irq_id=2; claim -> next cycle irq_req=0 (src2 prio 3 not > active 3).
REQ-038 src0 prio 1 ACTIVE, src3 prio 5 edge fires -> irq_id=4 (preemption); threshold=5 instead -> irq_req stays 0.
REQ-039 Edge src1 pulsed twice during its ACTIVE -> after complete_id=2, irq_req reasserts once, pending reads 0x2 then 0x0 after second claim.
REQ-040 claim with stall=1 -> ignored, irq_id unchanged; complete_id=3 for IDLE source -> no state change.
REQ-041 rst low while source ACTIVE and another PEND -> irq_req=0, pending=0, cfg_rdata at 0x10 = 0 immediately.

Source files
------------

// File: rtl/irq_arbiter.sv
// Priority interrupt arbiter: per-source sync + IDLE/PEND/ACTIVE tracking,
// nested preemption above the highest active priority, config register file.
module irq_arbiter_src (
    input  logic clk,
    input  logic rst,
    input  logic line,
    input  logic edge_mode,
    input  logic claim_hit,
    input  logic complete_hit,
    input  logic w1c,
    output logic pend,
    output logic active,
    output logic pend_next
);
    typedef enum logic [1:0] {IDLE, PEND, ACTIVE} state_t;

    state_t state;
    logic   sync1, sync2, prev;
    logic   rise, next_flag;

    assign rise      = sync2 & ~prev;
    // A fresh edge beats a same-cycle W1C of the queued flag.
    assign next_flag = (pend_next & ~w1c) | (edge_mode & rise);
    assign pend      = (state == PEND);
    assign active    = (state == ACTIVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            prev      <= 1'b0;
            pend_next <= 1'b0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
            prev  <= sync2;
            case (state)
                IDLE: begin
                    if (edge_mode ? rise : sync2) state <= PEND;
                end
                PEND: begin
                    if (claim_hit)                         state <= ACTIVE;
                    else if (edge_mode ? (w1c & ~rise) : ~sync2) state <= IDLE;
                end
                ACTIVE: begin
                    if (complete_hit) begin
                        state     <= next_flag ? PEND : IDLE;
                        pend_next <= 1'b0;
                    end else begin
                        pend_next <= next_flag;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module irq_arbiter #(
    parameter int                  NUM_SRC  = 4,
    parameter int                  PRIO_W   = 3,
    parameter logic [NUM_SRC-1:0]  EDGE_RST = '0,
    localparam int                 ID_W     = $clog2(NUM_SRC + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    input  logic              stall,
    input  logic              claim,
    input  logic              complete,
    input  logic [ID_W-1:0]   complete_id,
    output logic              irq_req,
    output logic [ID_W-1:0]   irq_id
);
    logic [NUM_SRC-1:0]             en, edge_m;
    logic [PRIO_W-1:0]              thr;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio;

    logic [NUM_SRC-1:0] pend, active, pend_next;
    logic [NUM_SRC-1:0] claim_hit, complete_hit, w1c;
    logic               claim_ok;
    logic [PRIO_W-1:0]  max_act, floor_p, win_prio;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;
    assign claim_ok     = claim & ~stall & irq_req;

    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        w1c          = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_hit[i]    = claim_ok && (irq_id == ID_W'(i + 1));
            complete_hit[i] = complete && !stall && (complete_id == ID_W'(i + 1)) && active[i];
            w1c[i]          = cfg_we && (cfg_addr == 8'h08) && cfg_wdata[i] && edge_m[i];
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_arbiter_src u_src (
            .clk          (clk),
            .rst          (rst),
            .line         (src_irq[g]),
            .edge_mode    (edge_m[g]),
            .claim_hit    (claim_hit[g]),
            .complete_hit (complete_hit[g]),
            .w1c          (w1c[g]),
            .pend         (pend[g]),
            .active       (active[g]),
            .pend_next    (pend_next[g])
        );
    end

    // A candidate must beat both the threshold and every in-service priority.
    always_comb begin
        max_act = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (active[i] && prio[i] > max_act) max_act = prio[i];
        floor_p   = (thr > max_act) ? thr : max_act;
        win_found = 1'b0;
        win_prio  = '0;
        win_id    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend[i] && en[i] && prio[i] != '0 && prio[i] > floor_p &&
                (!win_found || prio[i] > win_prio)) begin
                win_found = 1'b1;
                win_prio  = prio[i];
                win_id    = ID_W'(i + 1);
            end
        end
    end

    // The claimed source is still PEND this cycle, so blank the request once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_req <= 1'b0;
            irq_id  <= '0;
        end else if (claim_ok) begin
            irq_req <= 1'b0;
            irq_id  <= '0;
        end else begin
            irq_req <= win_found;
            irq_id  <= win_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en     <= '0;
            edge_m <= EDGE_RST;
            thr    <= '0;
            prio   <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                8'h00: en     <= cfg_wdata[NUM_SRC-1:0];
                8'h04: edge_m <= cfg_wdata[NUM_SRC-1:0];
                8'h08: ;
                8'h0C: thr    <= cfg_wdata[PRIO_W-1:0];
                default: begin
                    for (int i = 0; i < NUM_SRC; i++)
                        if (cfg_addr == 8'(16 + 4 * i)) prio[i] <= cfg_wdata[PRIO_W-1:0];
                end
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            8'h00: cfg_rdata[NUM_SRC-1:0] = en;
            8'h04: cfg_rdata[NUM_SRC-1:0] = edge_m;
            8'h08: cfg_rdata[NUM_SRC-1:0] = pend | pend_next;
            8'h0C: cfg_rdata[PRIO_W-1:0]  = thr;
            default: begin
                for (int i = 0; i < NUM_SRC; i++)
                    if (cfg_addr == 8'(16 + 4 * i)) cfg_rdata[PRIO_W-1:0] = prio[i];
            end
        endcase
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// Directed scenarios plus a random phase, checked cycle by cycle against a
// flag-based behavioural model of the interrupt rules.
`timescale 1ns/1ps
module tb_irq_arbiter;
    localparam int NS = 4;
    localparam int PW = 3;
    localparam int IW = 3;

    logic          clk = 1'b0, rst = 1'b0;
    logic [NS-1:0] src_irq = '0;
    logic          cfg_we = 1'b0;
    logic [7:0]    cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          stall = 1'b0, claim = 1'b0, complete = 1'b0;
    logic [IW-1:0] complete_id = '0;
    logic          irq_req;
    logic [IW-1:0] irq_id;

    int checks = 0, failures = 0;

    irq_arbiter #(.NUM_SRC(NS), .PRIO_W(PW)) dut (
        .clk(clk), .rst(rst), .src_irq(src_irq), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .stall(stall), .claim(claim), .complete(complete),
        .complete_id(complete_id), .irq_req(irq_req), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    // model: pending / in-service / queued-again flags per source
    bit [NS-1:0] en_m, edg_m, pend_m, act_m, nxt_m, s1, s2, pv;
    int          thr_m;
    int          prio_m [NS];
    bit          req_m;
    int          id_m;

    task automatic model_reset();
        en_m = '0; edg_m = '0; pend_m = '0; act_m = '0; nxt_m = '0;
        s1 = '0; s2 = '0; pv = '0; thr_m = 0; req_m = 0; id_m = 0;
        for (int i = 0; i < NS; i++) prio_m[i] = 0;
    endtask

    function automatic int winner();
        int ceil_p, best, bp;
        ceil_p = thr_m;
        for (int i = 0; i < NS; i++)
            if (act_m[i] && prio_m[i] > ceil_p) ceil_p = prio_m[i];
        best = 0; bp = 0;
        for (int i = 0; i < NS; i++)
            if (pend_m[i] && en_m[i] && prio_m[i] > ceil_p && prio_m[i] > bp) begin
                best = i + 1; bp = prio_m[i];
            end
        return best;
    endfunction

    function automatic logic [31:0] rd(input logic [7:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 8'h00) r = 32'(en_m);
        else if (a == 8'h04) r = 32'(edg_m);
        else if (a == 8'h08) r = 32'(pend_m | nxt_m);
        else if (a == 8'h0C) r = 32'(thr_m);
        else for (int i = 0; i < NS; i++) if (int'(a) == 16 + 4 * i) r = 32'(prio_m[i]);
        return r;
    endfunction

    task automatic model_update();
        int w, cid, comp, cix;
        bit ok, n;
        bit [NS-1:0] rise, w1c;
        w    = winner();
        ok   = claim && !stall && req_m;
        cid  = ok ? id_m : 0;
        cix  = int'(complete_id);
        comp = 0;
        if (complete && !stall && cix >= 1 && cix <= NS)
            if (act_m[cix-1]) comp = cix;
        rise = s2 & ~pv;
        w1c  = (cfg_we && cfg_addr == 8'h08) ? (cfg_wdata[NS-1:0] & edg_m) : '0;
        for (int i = 0; i < NS; i++) begin
            if (act_m[i]) begin
                n = (nxt_m[i] && !w1c[i]) || (edg_m[i] && rise[i]);
                if (comp == i + 1) begin act_m[i] = 0; pend_m[i] = n; nxt_m[i] = 0; end
                else nxt_m[i] = n;
            end else if (pend_m[i]) begin
                if (cid == i + 1) begin pend_m[i] = 0; act_m[i] = 1; end
                else if (edg_m[i] ? (w1c[i] && !rise[i]) : !s2[i]) pend_m[i] = 0;
            end else if (edg_m[i] ? rise[i] : s2[i]) pend_m[i] = 1;
        end
        if (cfg_we) begin
            if (cfg_addr == 8'h00) en_m = cfg_wdata[NS-1:0];
            else if (cfg_addr == 8'h04) edg_m = cfg_wdata[NS-1:0];
            else if (cfg_addr == 8'h0C) thr_m = int'(cfg_wdata[PW-1:0]);
            else for (int i = 0; i < NS; i++)
                if (int'(cfg_addr) == 16 + 4 * i) prio_m[i] = int'(cfg_wdata[PW-1:0]);
        end
        req_m = !ok && (w != 0);
        id_m  = ok ? 0 : w;
        pv = s2; s2 = s1; s1 = src_irq;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk); #1;
        chk("irq_req", 32'(irq_req), 32'(req_m));
        chk("irq_id", 32'(irq_id), 32'(id_m));
        chk("cfg_rdata", cfg_rdata, rd(cfg_addr));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0; cfg_wdata = '0; cfg_addr = 8'h08;
    endtask

    task automatic do_claim();
        claim = 1'b1; step(); claim = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete = 1'b1; complete_id = IW'(id); step(); complete = 1'b0;
    endtask

    task automatic pulse(input int b);
        src_irq[b] = 1'b1; steps(2); src_irq[b] = 1'b0; steps(3);
    endtask

    logic [7:0] addrs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h03};

    initial begin
        model_reset();
        #12;
        chk("rst_req", 32'(irq_req), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        cfg_addr = 8'h04; #1;
        chk("rst_edge", cfg_rdata, 32'd0);
        rst = 1'b1;

        // level source latency
        wr(8'h00, 32'h1); wr(8'h10, 32'd2);
        src_irq[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin step(); chk("lat_early", 32'(irq_req), 32'd0); end
        step();
        chk("lat4_req", 32'(irq_req), 32'd1);
        chk("lat4_id", 32'(irq_id), 32'd1);
        do_claim();
        chk("claim_drop", 32'(irq_req), 32'd0);
        src_irq[0] = 1'b0; steps(3); do_complete(1); steps(4);

        // tie on equal priority, no self-preemption
        wr(8'h00, 32'hF); wr(8'h14, 32'd3); wr(8'h18, 32'd3);
        src_irq = 4'b0110; steps(5);
        chk("tie_id", 32'(irq_id), 32'd2);
        do_claim();
        chk("tie_claim", 32'(irq_req), 32'd0);
        steps(2);
        chk("tie_blocked", 32'(irq_req), 32'd0);
        src_irq = '0; steps(4); do_complete(2); steps(3);

        // preemption by edge source, then threshold blocks it
        wr(8'h04, 32'h8); wr(8'h10, 32'd1); wr(8'h1C, 32'd5);
        src_irq[0] = 1'b1; steps(5);
        chk("pre_id1", 32'(irq_id), 32'd1);
        do_claim();
        src_irq[3] = 1'b1; steps(2); src_irq[3] = 1'b0; steps(2);
        chk("preempt_req", 32'(irq_req), 32'd1);
        chk("preempt_id", 32'(irq_id), 32'd4);
        do_claim(); step(); do_complete(4); step();
        wr(8'h0C, 32'd5);
        pulse(3);
        chk("thr_req", 32'(irq_req), 32'd0);
        chk("thr_pend", cfg_rdata, 32'h8);
        wr(8'h08, 32'h8);
        chk("w1c_pend", cfg_rdata, 32'h0);
        wr(8'h0C, 32'd0);
        src_irq[0] = 1'b0; steps(3); do_complete(1); steps(3);

        // double edge during service merges into one re-request
        wr(8'h04, 32'h2);
        pulse(1);
        chk("e1_id", 32'(irq_id), 32'd2);
        do_claim();
        pulse(1); pulse(1);
        chk("pnext_pend", cfg_rdata, 32'h2);
        do_complete(2); step();
        chk("re_req", 32'(irq_req), 32'd1);
        chk("re_id", 32'(irq_id), 32'd2);
        do_claim();
        chk("re_pend0", cfg_rdata, 32'h0);
        steps(3);
        chk("re_once", 32'(irq_req), 32'd0);
        do_complete(2); steps(2);

        // stalled claim and bogus complete are ignored
        pulse(1);
        stall = 1'b1; claim = 1'b1; step(); claim = 1'b0; stall = 1'b0;
        chk("stall_req", 32'(irq_req), 32'd1);
        chk("stall_id", 32'(irq_id), 32'd2);
        do_complete(3);
        chk("bogus_req", 32'(irq_req), 32'd1);
        chk("bogus_pend", cfg_rdata, 32'h2);

        // reset with one ACTIVE and one PEND
        do_claim();
        src_irq[0] = 1'b1; steps(4);
        chk("pre_rst_pend", cfg_rdata, 32'h1);
        rst = 1'b0; #1;
        chk("arst_req", 32'(irq_req), 32'd0);
        chk("arst_pend", cfg_rdata, 32'h0);
        cfg_addr = 8'h10; #1;
        chk("arst_prio0", cfg_rdata, 32'h0);
        model_reset();
        src_irq = '0;
        @(posedge clk); #3;
        rst = 1'b1;
        cfg_addr = 8'h08;
        steps(2);

        // random traffic against the model
        wr(8'h00, 32'hF);
        for (int i = 0; i < NS; i++) wr(8'(16 + 4 * i), 32'(i + 2));
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < NS; b++)
                if ($urandom_range(0, 9) == 0) src_irq[b] = ~src_irq[b];
            stall       = ($urandom_range(0, 3) == 0);
            claim       = ($urandom_range(0, 2) == 0);
            complete    = ($urandom_range(0, 3) == 0);
            complete_id = IW'($urandom_range(0, 7));
            cfg_we      = ($urandom_range(0, 11) == 0);
            if (cfg_we) begin
                cfg_addr  = addrs[$urandom_range(0, 7)];
                cfg_wdata = $urandom;
                if (cfg_addr == 8'h0C) cfg_wdata = 32'($urandom_range(0, 3));
            end else begin
                cfg_addr  = addrs[$urandom_range(0, 9)];
                cfg_wdata = '0;
            end
            step();
        end
        cfg_we = 1'b0; claim = 1'b0; complete = 1'b0; stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
